// File: rtl/bignum_pkg.sv
// Shared types and default widths for the big-number command dispatcher.
package bignum_pkg;

    localparam int unsigned ADRBW = 20;
    localparam int unsigned WRDBW = 16;
    localparam int unsigned VARBW = 17;
    localparam int unsigned OPBW  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [OPBW-1:0]  op;
        logic [VARBW-1:0] varsize;
        logic [ADRBW-1:0] x1addr;
        logic [ADRBW-1:0] x2addr;
        logic [ADRBW-1:0] x3addr;
    } cmd_t;

endpackage

// File: rtl/bignum_cmd_fifo.sv
// Synchronous FIFO of dispatcher commands; overflowing pushes and underflowing pops are dropped.
module bignum_cmd_fifo
    import bignum_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  cmd_t din,
    output cmd_t dout,
    output logic full,
    output logic empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cmd_t            mem [DEPTH];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [PW:0]     count_q;
    logic            do_push, do_pop;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= din;
    end

endmodule

// File: rtl/bignum_op_dispatcher.sv
// Queues bignum commands, launches them one at a time on the arithmetic units,
// and arbitrates the single-port operand SRAM between the active unit and the host.
module bignum_op_dispatcher #(
    parameter int unsigned NUNITS  = 2,
    parameter int unsigned ADRBW   = 20,
    parameter int unsigned WRDBW   = 16,
    parameter int unsigned VARBW   = 17,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 500000,
    parameter int unsigned OPBW    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [OPBW-1:0]          cmd_op,
    input  logic [VARBW-1:0]         cmd_varsize,
    input  logic [ADRBW-1:0]         cmd_x1addr,
    input  logic [ADRBW-1:0]         cmd_x2addr,
    input  logic [ADRBW-1:0]         cmd_x3addr,
    output logic [NUNITS-1:0]        u_valid,
    output logic [VARBW-1:0]         u_varsize,
    output logic [ADRBW-1:0]         u_x1addr,
    output logic [ADRBW-1:0]         u_x2addr,
    output logic [ADRBW-1:0]         u_x3addr,
    input  logic [NUNITS-1:0]        u_wen,
    input  logic [NUNITS*ADRBW-1:0]  u_addr,
    input  logic [NUNITS*WRDBW-1:0]  u_wdata,
    input  logic [NUNITS-1:0]        u_done,
    output logic [WRDBW-1:0]         u_rdata,
    input  logic                     host_req,
    output logic                     host_gnt,
    input  logic [ADRBW-1:0]         host_addr,
    input  logic                     host_wen,
    input  logic [WRDBW-1:0]         host_wdata,
    output logic [WRDBW-1:0]         host_rdata,
    output logic [ADRBW-1:0]         sram_addr,
    output logic                     sram_wen,
    output logic [WRDBW-1:0]         sram_wdata,
    input  logic [WRDBW-1:0]         sram_rdata,
    output logic                     busy,
    output logic                     op_done,
    output logic                     op_err,
    output logic                     op_timeout
);
    import bignum_pkg::*;

    localparam int unsigned IDXW = (NUNITS > 1) ? $clog2(NUNITS) : 1;
    localparam int unsigned WDW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_e             state_q, state_d;
    cmd_t               cmd_in, head, act_q;
    logic               fifo_full, fifo_empty;
    logic               pop, dispatch, err, done, tmo;
    logic [IDXW-1:0]    idx_q;
    logic [WDW-1:0]     wdog_q;
    logic [NUNITS-1:0]  u_valid_q;
    logic               op_done_q, op_err_q, op_timeout_q;
    logic [ADRBW-1:0]   sram_addr_q;

    always_comb begin
        cmd_in.op      = cmd_op;
        cmd_in.varsize = cmd_varsize;
        cmd_in.x1addr  = cmd_x1addr;
        cmd_in.x2addr  = cmd_x2addr;
        cmd_in.x3addr  = cmd_x3addr;
    end

    bignum_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .pop   (pop),
        .din   (cmd_in),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign cmd_ready  = !fifo_full;
    assign busy       = (state_q != IDLE) || !fifo_empty;
    assign u_valid    = u_valid_q;
    assign op_done    = op_done_q;
    assign op_err     = op_err_q;
    assign op_timeout = op_timeout_q;
    assign u_varsize  = act_q.varsize;
    assign u_x1addr   = act_q.x1addr;
    assign u_x2addr   = act_q.x2addr;
    assign u_x3addr   = act_q.x3addr;
    assign u_rdata    = sram_rdata;
    assign host_rdata = sram_rdata;

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        dispatch   = 1'b0;
        err        = 1'b0;
        done       = 1'b0;
        tmo        = 1'b0;
        host_gnt   = 1'b0;
        sram_addr  = sram_addr_q;
        sram_wen   = 1'b0;
        sram_wdata = '0;
        unique case (state_q)
            IDLE: begin
                if (host_req) begin
                    host_gnt   = 1'b1;
                    sram_addr  = host_addr;
                    sram_wen   = host_wen;
                    sram_wdata = host_wdata;
                end else if (!fifo_empty) begin
                    pop = 1'b1;
                    if (int'(head.op) < int'(NUNITS)) begin
                        dispatch = 1'b1;
                        state_d  = RUN;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            RUN: begin
                sram_addr  = u_addr[int'(idx_q)*ADRBW +: ADRBW];
                sram_wdata = u_wdata[int'(idx_q)*WRDBW +: WRDBW];
                // the start-pulse cycle is the first RUN cycle; a done seen then is stale
                done       = u_done[idx_q] && (u_valid_q == '0);
                tmo        = !done && (wdog_q == WDW'(TIMEOUT - 1));
                sram_wen   = u_wen[idx_q] && !tmo;
                if (done || tmo) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            act_q        <= '0;
            idx_q        <= '0;
            wdog_q       <= '0;
            u_valid_q    <= '0;
            op_done_q    <= 1'b0;
            op_err_q     <= 1'b0;
            op_timeout_q <= 1'b0;
            sram_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            sram_addr_q  <= sram_addr;
            u_valid_q    <= '0;
            op_done_q    <= done;
            op_err_q     <= err;
            op_timeout_q <= tmo;
            if (dispatch) begin
                act_q     <= head;
                idx_q     <= IDXW'(head.op);
                u_valid_q <= NUNITS'(1) << IDXW'(head.op);
                wdog_q    <= '0;
            end else if (state_q == RUN) begin
                wdog_q <= wdog_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bignum_op_dispatcher.sv
// Self-checking bench: directed multi-cycle sequences, a command table, and a randomized
// run compared against a queue-based behavioural model of the dispatcher.
module tb_bignum_op_dispatcher;
    import bignum_pkg::*;

    localparam int unsigned NU = 2;
    localparam int unsigned AW = 20;
    localparam int unsigned WW = 16;
    localparam int unsigned VW = 17;
    localparam int unsigned DP = 4;
    localparam int unsigned TO = 16;
    localparam int unsigned OW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid, cmd_ready;
    logic [OW-1:0]     cmd_op;
    logic [VW-1:0]     cmd_varsize;
    logic [AW-1:0]     cmd_x1addr, cmd_x2addr, cmd_x3addr;
    logic [NU-1:0]     u_valid;
    logic [VW-1:0]     u_varsize;
    logic [AW-1:0]     u_x1addr, u_x2addr, u_x3addr;
    logic [NU-1:0]     u_wen;
    logic [NU*AW-1:0]  u_addr;
    logic [NU*WW-1:0]  u_wdata;
    logic [NU-1:0]     u_done;
    logic [WW-1:0]     u_rdata;
    logic              host_req, host_gnt, host_wen;
    logic [AW-1:0]     host_addr;
    logic [WW-1:0]     host_wdata, host_rdata;
    logic [AW-1:0]     sram_addr;
    logic              sram_wen;
    logic [WW-1:0]     sram_wdata, sram_rdata;
    logic              busy, op_done, op_err, op_timeout;

    int unsigned tests = 0;
    int unsigned failed = 0;

    bignum_op_dispatcher #(
        .NUNITS  (NU),
        .ADRBW   (AW),
        .WRDBW   (WW),
        .VARBW   (VW),
        .DEPTH   (DP),
        .TIMEOUT (TO),
        .OPBW    (OW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_varsize (cmd_varsize),
        .cmd_x1addr  (cmd_x1addr),
        .cmd_x2addr  (cmd_x2addr),
        .cmd_x3addr  (cmd_x3addr),
        .u_valid     (u_valid),
        .u_varsize   (u_varsize),
        .u_x1addr    (u_x1addr),
        .u_x2addr    (u_x2addr),
        .u_x3addr    (u_x3addr),
        .u_wen       (u_wen),
        .u_addr      (u_addr),
        .u_wdata     (u_wdata),
        .u_done      (u_done),
        .u_rdata     (u_rdata),
        .host_req    (host_req),
        .host_gnt    (host_gnt),
        .host_addr   (host_addr),
        .host_wen    (host_wen),
        .host_wdata  (host_wdata),
        .host_rdata  (host_rdata),
        .sram_addr   (sram_addr),
        .sram_wen    (sram_wen),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata),
        .busy        (busy),
        .op_done     (op_done),
        .op_err      (op_err),
        .op_timeout  (op_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] op;
        logic [VW-1:0] vs;
        logic [AW-1:0] x1, x2, x3;
        logic [NU-1:0] uv;
        logic          err;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_valid = 0; cmd_op = '0; cmd_varsize = '0;
        cmd_x1addr = '0; cmd_x2addr = '0; cmd_x3addr = '0;
        u_wen = '0; u_addr = '0; u_wdata = '0; u_done = '0;
        host_req = 0; host_addr = '0; host_wen = 0; host_wdata = '0;
        sram_rdata = '0;
    endtask

    task automatic send(input logic [OW-1:0] op, input logic [VW-1:0] vs,
                        input logic [AW-1:0] x1, input logic [AW-1:0] x2, input logic [AW-1:0] x3);
        cmd_valid = 1; cmd_op = op; cmd_varsize = vs;
        cmd_x1addr = x1; cmd_x2addr = x2; cmd_x3addr = x3;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        #1;
        chk("rst_u_valid", 32'(u_valid), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_op_done", 32'(op_done), 0);
        chk("rst_op_err", 32'(op_err), 0);
        chk("rst_op_timeout", 32'(op_timeout), 0);
        chk("rst_host_gnt", 32'(host_gnt), 0);
        chk("rst_sram_wen", 32'(sram_wen), 0);
        chk("rst_sram_addr", 32'(sram_addr), 0);
        chk("rst_u_x1addr", 32'(u_x1addr), 0);
        cyc();
        rst_n = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [OW-1:0] ops [4];
        vec_t          tbl [6];
        logic [VW-1:0] lvs;
        logic [AW-1:0] lx1, lx3;
        cmd_t          mq [$];
        cmd_t          act, c;
        bit            running, dn, tm, rdy, ee, ed, et, ewen;
        int unsigned   age, ix;
        logic [NU-1:0] euv;
        logic [AW-1:0] laddr, eaddr;
        logic [NU-1:0] one;

        ops[0] = 0; ops[1] = 1; ops[2] = 1; ops[3] = 0;
        tbl[0] = '{4'd0,  17'h1FFFF, 20'hFFFFF, 20'h00000, 20'h12345, 2'b01, 1'b0};
        tbl[1] = '{4'd2,  17'h00011, 20'h11111, 20'h22222, 20'h33333, 2'b00, 1'b1};
        tbl[2] = '{4'd1,  17'h00001, 20'h00001, 20'h00002, 20'h00003, 2'b10, 1'b0};
        tbl[3] = '{4'd15, 17'h00022, 20'h44444, 20'h55555, 20'h66666, 2'b00, 1'b1};
        tbl[4] = '{4'd1,  17'h00000, 20'h00000, 20'h00000, 20'h00000, 2'b10, 1'b0};
        tbl[5] = '{4'd0,  17'h00040, 20'hABCDE, 20'h0F0F0, 20'h70707, 2'b01, 1'b0};

        rst_n = 0;
        idle_inputs();
        #12;
        do_reset();

        // single command: latency, SRAM mux, done
        cyc(); send(0, 32, 0, 5, 10);
        cyc(); cmd_valid = 0; #1;
        chk("lat_decide_uv", 32'(u_valid), 0);
        chk("lat_busy", 32'(busy), 1);
        cyc(); u_addr = {20'h0, 20'h00777}; u_wen = 2'b01; u_wdata = {16'h0, 16'hBEEF}; #1;
        chk("lat_uv", 32'(u_valid), 1);
        chk("lat_varsize", 32'(u_varsize), 32);
        chk("lat_x2", 32'(u_x2addr), 5);
        chk("lat_x3", 32'(u_x3addr), 10);
        chk("run_addr", 32'(sram_addr), 32'h777);
        chk("run_wen", 32'(sram_wen), 1);
        chk("run_wdata", 32'(sram_wdata), 32'hBEEF);
        cyc(); u_done = 2'b01; u_addr = {20'h0, 20'h00778}; #1;
        chk("lat_uv_one_cycle", 32'(u_valid), 0);
        chk("run_addr2", 32'(sram_addr), 32'h778);
        chk("early_done", 32'(op_done), 0);
        cyc(); u_done = 0; u_wen = 0; #1;
        chk("op_done", 32'(op_done), 1);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_wen", 32'(sram_wen), 0);
        chk("idle_addr_hold", 32'(sram_addr), 32'h778);
        cyc(); #1;
        chk("op_done_pulse", 32'(op_done), 0);

        // host priority in IDLE while the FIFO fills, then in-order dispatch
        cyc(); host_req = 1; host_addr = 3; host_wen = 1; host_wdata = 16'h1234;
        for (int k = 0; k < 4; k++) begin
            send(ops[k], VW'(k + 1), AW'(32'h100 + k), 0, 0);
            #1;
            chk("fill_ready", 32'(cmd_ready), 1);
            chk("host_gnt", 32'(host_gnt), 1);
            chk("host_addr", 32'(sram_addr), 3);
            chk("host_wen", 32'(sram_wen), 1);
            chk("host_wdata", 32'(sram_wdata), 32'h1234);
            chk("host_no_dispatch", 32'(u_valid), 0);
            cyc();
        end
        send(0, 9, 20'hBAD, 0, 0); #1;
        chk("full_ready", 32'(cmd_ready), 0);
        chk("full_uv", 32'(u_valid), 0);
        cyc(); cmd_valid = 0; host_req = 0; host_wen = 0; #1;
        chk("release_gnt", 32'(host_gnt), 0);
        chk("still_full", 32'(cmd_ready), 0);
        for (int k = 0; k < 4; k++) begin
            one = NU'(1) << ops[k];
            cyc(); #1;
            chk("order_uv", 32'(u_valid), 32'(one));
            chk("order_x1", 32'(u_x1addr), 32'h100 + k);
            chk("order_vs", 32'(u_varsize), k + 1);
            if (k == 0) chk("ready_after_pop", 32'(cmd_ready), 1);
            cyc(); host_req = 1; host_wen = 1; u_done = one;
            u_wen = (k % 2 == 0) ? one : ~one; #1;
            chk("run_host_gnt", 32'(host_gnt), 0);
            chk("run_wen_active", 32'(sram_wen), (k % 2 == 0) ? 1 : 0);
            cyc(); host_req = 0; host_wen = 0; u_done = 0; u_wen = 0; #1;
            chk("order_done", 32'(op_done), 1);
        end
        cyc(); #1;
        chk("fifth_dropped_uv", 32'(u_valid), 0);
        chk("fifth_dropped_busy", 32'(busy), 0);

        // illegal op followed by a legal one
        cyc(); send(5, 1, 20'h55, 0, 0);
        cyc(); send(1, 7, 20'hA1, 20'hA2, 20'hA3);
        cyc(); cmd_valid = 0; #1;
        chk("err_pulse", 32'(op_err), 1);
        chk("err_no_uv", 32'(u_valid), 0);
        chk("err_fields_hold", 32'(u_x1addr), 32'h103);
        cyc(); #1;
        chk("err_pulse_end", 32'(op_err), 0);
        chk("after_err_uv", 32'(u_valid), 32'b10);
        chk("after_err_x1", 32'(u_x1addr), 32'hA1);
        cyc(); u_done = 2'b10;
        cyc(); u_done = 0; #1;
        chk("after_err_done", 32'(op_done), 1);

        // watchdog abort; done from the inactive unit is ignored
        cyc(); send(0, 3, 20'hC1, 0, 0);
        cyc(); cmd_valid = 0; u_done = 2'b10; u_wen = 2'b01;
        for (int r = 1; r <= 16; r++) begin
            cyc(); #1;
            if (r == 1) chk("tmo_uv", 32'(u_valid), 1);
            chk("tmo_not_yet", 32'(op_timeout | op_done), 0);
            chk("tmo_wen", 32'(sram_wen), (r < 16) ? 1 : 0);
        end
        cyc(); u_done = 0; u_wen = 0; #1;
        chk("tmo_pulse", 32'(op_timeout), 1);
        chk("tmo_busy", 32'(busy), 0);
        chk("tmo_no_done", 32'(op_done), 0);
        cyc(); #1;
        chk("tmo_pulse_end", 32'(op_timeout), 0);

        // command table
        lvs = 3; lx1 = 20'hC1; lx3 = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(); send(tbl[i].op, tbl[i].vs, tbl[i].x1, tbl[i].x2, tbl[i].x3);
            cyc(); cmd_valid = 0;
            cyc(); #1;
            if (tbl[i].uv != 0) begin
                lvs = tbl[i].vs; lx1 = tbl[i].x1; lx3 = tbl[i].x3;
            end
            chk("tbl_uv", 32'(u_valid), 32'(tbl[i].uv));
            chk("tbl_err", 32'(op_err), 32'(tbl[i].err));
            chk("tbl_vs", 32'(u_varsize), 32'(lvs));
            chk("tbl_x1", 32'(u_x1addr), 32'(lx1));
            chk("tbl_x3", 32'(u_x3addr), 32'(lx3));
            if (tbl[i].uv != 0) begin
                cyc(); u_done = tbl[i].uv;
                cyc(); u_done = 0; #1;
                chk("tbl_done", 32'(op_done), 1);
            end
        end

        // randomized run against the queue model, with a reset in the middle
        cyc();
        for (int n = 0; n < 1500; n++) begin
            if (n == 0 || n == 700) begin
                do_reset();
                mq.delete();
                running = 0; age = 0; act = '0;
                euv = '0; ed = 0; ee = 0; et = 0; laddr = '0;
            end
            cyc();
            cmd_valid   = ($urandom_range(0, 9) < 4);
            ix          = $urandom_range(0, 9);
            cmd_op      = (ix < 4) ? 4'd0 : (ix < 8) ? 4'd1 : OW'($urandom_range(2, 15));
            cmd_varsize = VW'($urandom);
            cmd_x1addr  = AW'($urandom);
            cmd_x2addr  = AW'($urandom);
            cmd_x3addr  = AW'($urandom);
            host_req    = ($urandom_range(0, 3) == 0);
            host_addr   = AW'($urandom);
            host_wen    = 1'($urandom);
            host_wdata  = WW'($urandom);
            u_addr      = {AW'($urandom), AW'($urandom)};
            u_wen       = NU'($urandom);
            u_wdata     = {WW'($urandom), WW'($urandom)};
            u_done      = {($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0)};
            sram_rdata  = WW'($urandom);
            #1;
            ix    = int'(act.op[0]);
            dn    = running && u_done[ix] && (age > 0);
            tm    = running && !dn && (age == TO - 1);
            eaddr = running ? u_addr[ix*AW +: AW] : (host_req ? host_addr : laddr);
            ewen  = running ? (u_wen[ix] && !tm) : (host_req && host_wen);
            rdy   = (mq.size() < DP);
            chk("rnd_ready", 32'(cmd_ready), 32'(rdy));
            chk("rnd_busy", 32'(busy), 32'(running || mq.size() != 0));
            chk("rnd_gnt", 32'(host_gnt), 32'(!running && host_req));
            chk("rnd_addr", 32'(sram_addr), 32'(eaddr));
            chk("rnd_wen", 32'(sram_wen), 32'(ewen));
            chk("rnd_uv", 32'(u_valid), 32'(euv));
            chk("rnd_done", 32'(op_done), 32'(ed));
            chk("rnd_err", 32'(op_err), 32'(ee));
            chk("rnd_tmo", 32'(op_timeout), 32'(et));
            chk("rnd_vs", 32'(u_varsize), 32'(act.varsize));
            chk("rnd_x1", 32'(u_x1addr), 32'(act.x1addr));
            chk("rnd_x2", 32'(u_x2addr), 32'(act.x2addr));
            chk("rnd_rdata", 32'({u_rdata, host_rdata}), 32'({sram_rdata, sram_rdata}));
            laddr = eaddr;
            euv = '0; ed = dn; ee = 0; et = tm;
            if (running) begin
                if (dn || tm) running = 0;
                else age++;
            end else if (!host_req && mq.size() != 0) begin
                c = mq.pop_front();
                if (int'(c.op) < int'(NU)) begin
                    running = 1; age = 0; act = c;
                    euv = NU'(1) << c.op;
                end else begin
                    ee = 1;
                end
            end
            if (cmd_valid && rdy) begin
                c.op = cmd_op; c.varsize = cmd_varsize;
                c.x1addr = cmd_x1addr; c.x2addr = cmd_x2addr; c.x3addr = cmd_x3addr;
                mq.push_back(c);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
